// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces an asynchronous PLL lock flag, releases NUM_CH
// per-domain resets in index order with a fixed gap, and generates a divided
// clock-enable strobe for each released domain on clk_100Mhz.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_WAIT   | all domains held in reset, waiting for synchronised lock
// S_STABLE | lock seen, counting consecutive locked cycles (debounce)
// S_REL    | releasing domains one at a time, GAP cycles apart
// S_RUN    | every domain released, watching for lock loss
module reset_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int LOCK_STABLE = 1024,
  parameter int GAP         = 16,
  parameter int DIV_W       = 8
) (
  input  logic                    clk_100Mhz,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] divs,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    all_ready,
  output logic [7:0]              lock_lost_cnt
);

  localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE + 1) : 1;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_CH    = NUM_CH'(1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_REL    = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t            state;
  logic              sync_1;
  logic              locked_s;
  logic [STAB_W-1:0] stable_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  next_idx;
  logic              lock_drop;
  logic [DIV_W-1:0]  div_cnt [NUM_CH];

  assign next_idx = idx + 1'b1;

  // Lock loss only matters once the sequence has left S_WAIT.
  assign lock_drop = (state != S_WAIT) && !locked_s;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      sync_1   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_1   <= pll_locked;
      locked_s <= sync_1;
    end
  end

  // Sequencing FSM: debounce, ordered release, lock-loss recovery.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state         <= S_WAIT;
      rst_out       <= '1;
      all_ready     <= 1'b0;
      lock_lost_cnt <= 8'd0;
      stable_cnt    <= '0;
      gap_cnt       <= '0;
      idx           <= '0;
    end else if (lock_drop) begin
      state      <= S_WAIT;
      rst_out    <= '1;
      all_ready  <= 1'b0;
      stable_cnt <= '0;
      gap_cnt    <= '0;
      idx        <= '0;
      if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end else begin
      case (state)
        S_WAIT: begin
          rst_out    <= '1;
          stable_cnt <= '0;
          if (locked_s) state <= S_STABLE;
        end
        S_STABLE: begin
          // locked_s is known high here; a low would have taken lock_drop.
          if (stable_cnt == STAB_LAST) begin
            stable_cnt <= '0;
            rst_out[0] <= 1'b0;
            idx        <= '0;
            gap_cnt    <= '0;
            if (NUM_CH == 1) begin
              all_ready <= 1'b1;
              state     <= S_RUN;
            end else begin
              state <= S_REL;
            end
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        S_REL: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            // Shifted mask keeps the index in range even when NUM_CH is 1.
            rst_out <= rst_out & ~(ONE_CH << next_idx);
            idx     <= next_idx;
            if (next_idx == IDX_LAST) begin
              all_ready <= 1'b1;
              state     <= S_RUN;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

  // Per-domain clock-enable dividers, idle while the domain is in reset.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      ce_out <= '0;
      for (int k = 0; k < NUM_CH; k++) div_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rst_out[k] || lock_drop) begin
          div_cnt[k] <= '0;
          ce_out[k]  <= 1'b0;
        end else if (div_cnt[k] >= divs[k*DIV_W +: DIV_W]) begin
          // >= so a divisor lowered below the running count wraps at once.
          div_cnt[k] <= '0;
          ce_out[k]  <= 1'b1;
        end else begin
          div_cnt[k] <= div_cnt[k] + 1'b1;
          ce_out[k]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_CH=3, LOCK_STABLE=8, GAP=4.
module tb_reset_sequencer;

  logic        clk_100Mhz = 1'b0;
  logic        reset      = 1'b1;
  logic        pll_locked = 1'b0;
  logic [23:0] divs       = {8'd0, 8'd2, 8'd3};
  logic [2:0]  rst_out;
  logic [2:0]  ce_out;
  logic        all_ready;
  logic [7:0]  lock_lost_cnt;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_CH(3),
    .LOCK_STABLE(8),
    .GAP(4),
    .DIV_W(8)
  ) dut (
    .clk_100Mhz(clk_100Mhz),
    .reset(reset),
    .pll_locked(pll_locked),
    .divs(divs),
    .rst_out(rst_out),
    .ce_out(ce_out),
    .all_ready(all_ready),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  task automatic tick();
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag, input logic [7:0] lost);
    chk({tag, "_rst"}, 32'(rst_out), 32'h7);
    chk({tag, "_ce"}, 32'(ce_out), 32'h0);
    chk({tag, "_rdy"}, 32'(all_ready), 32'h0);
    chk({tag, "_lost"}, 32'(lock_lost_cnt), 32'(lost));
  endtask

  // e=0 is the next edge; rst_out[0] is expected to fall at edge e=r0.
  // Channel divisors are 3, 2, 0, so first pulses land div+1 edges after
  // each release and then repeat every div+1 edges.
  task automatic seq_check(input string tag, input int r0, input int n, input logic [7:0] lost);
    logic [2:0] exp_rst;
    logic [2:0] exp_ce;
    for (int e = 0; e < n; e++) begin
      tick();
      exp_rst = {(e < r0 + 8), (e < r0 + 4), (e < r0)};
      exp_ce[0] = (e >= r0 + 4) && (((e - r0 - 4) % 4) == 0);
      exp_ce[1] = (e >= r0 + 7) && (((e - r0 - 7) % 3) == 0);
      exp_ce[2] = (e >= r0 + 9);
      chk($sformatf("%s_rst_e%0d", tag, e), 32'(rst_out), 32'(exp_rst));
      chk($sformatf("%s_ce_e%0d", tag, e), 32'(ce_out), 32'(exp_ce));
      chk($sformatf("%s_rdy_e%0d", tag, e), 32'(all_ready), 32'(e >= r0 + 8));
    end
    chk({tag, "_lost_end"}, 32'(lock_lost_cnt), 32'(lost));
  endtask

  initial begin
    // Reset held with lock already high: outputs stay at reset values.
    reset      = 1'b1;
    pll_locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_vals($sformatf("rst_hold%0d", i), 8'd0);
    end
    reset = 1'b0;

    // Clean release sequence and clock enables.
    seq_check("seq1", 10, 41, 8'd0);

    // Lock loss in S_RUN takes effect on the third edge.
    pll_locked = 1'b0;
    tick();
    tick();
    chk("drop_e2_rst", 32'(rst_out), 32'h0);
    chk("drop_e2_rdy", 32'(all_ready), 32'h1);
    tick();
    chk_reset_vals("drop_e3", 8'd1);
    // Staying unlocked in S_WAIT must not count again.
    for (int i = 0; i < 5; i++) tick();
    chk("wait_nocount", 32'(lock_lost_cnt), 32'd1);

    // Glitch during debounce restarts it.
    reset = 1'b1;
    tick();
    chk_reset_vals("rst2", 8'd0);
    reset = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("glitch_pre_rst", 32'(rst_out), 32'h7);
    chk("glitch_pre_lost", 32'(lock_lost_cnt), 32'd0);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    seq_check("glitch", 10, 30, 8'd1);

    // Repeated lock losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      for (int j = 0; j < 5; j++) tick();
      pll_locked = 1'b0;
      for (int j = 0; j < 4; j++) tick();
      chk($sformatf("sat_%0d", i), 32'(lock_lost_cnt), (i + 2 > 255) ? 32'd255 : 32'(i + 2));
    end
    chk("sat_rst", 32'(rst_out), 32'h7);

    // Reset midway through release, then a full identical rerun.
    reset      = 1'b1;
    pll_locked = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("mid_rst", 32'(rst_out), 32'h6);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_reset", 8'd0);
    reset = 1'b0;
    seq_check("rerun", 10, 41, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-PLL reset/clock block.
- Debounces an asynchronous PLL lock signal, then releases NUM_CH per-domain resets one after another with a programmable gap.
- Generates a divided clock-enable strobe per domain, so the subsystems run on clk_100Mhz with enables instead of extra PLL outputs.
- Sits at the top level between the PLL wrapper and the memory, video and USB subsystems.

Parameters:
- NUM_CH, 3: number of reset/enable channels (1..8).
- LOCK_STABLE, 1024: cycles pll_locked must stay high before the first release (>=1).
- GAP, 16: cycles between consecutive channel releases (>=1).
- DIV_W, 8: width of each per-channel divisor.

Ports:
- clk_100Mhz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pll_locked  input  1  PLL lock flag, asynchronous to clk_100Mhz.
- divs  input  NUM_CH*DIV_W  per-channel divisor; channel k uses bits [k*DIV_W +: DIV_W].
- rst_out  output  NUM_CH  per-domain reset, active-high.
- ce_out  output  NUM_CH  per-domain clock-enable strobe.
- all_ready  output  1  high when every rst_out bit is released.
- lock_lost_cnt  output  8  saturating count of lock losses after the sequence has started.

Behaviour:
- reset=1 at an edge sets: rst_out all 1, ce_out 0, all_ready 0, lock_lost_cnt 0, both synchroniser FFs 0, state S_WAIT, all counters 0. reset overrides every other input.
- pll_locked passes through a 2-FF synchroniser to give locked_s. This adds 2 cycles of latency; no other logic samples pll_locked directly.
- FSM states: S_WAIT, S_STABLE, S_REL, S_RUN.
- S_WAIT:
  - rst_out all 1; stable counter held at 0.
  - locked_s=1 -> S_STABLE.
- S_STABLE:
  - Counts the cycles during which locked_s=1.
  - After LOCK_STABLE consecutive such cycles: enter S_REL with idx=0 and deassert rst_out[0] at the same edge.
- S_REL:
  - A gap counter counts GAP cycles, then deasserts rst_out[idx+1].
  - When rst_out[NUM_CH-1] falls, all_ready rises at the same edge and the FSM enters S_RUN.
  - NUM_CH=1: all_ready rises together with rst_out[0].
- S_RUN: holds until lock is lost.
- Release timing, required exactly:
  - If the first edge sampling pll_locked=1 is E0, rst_out[0] falls at edge E0+2+LOCK_STABLE.
  - rst_out[k] falls k*GAP edges after rst_out[0].
- Lock loss: in any state other than S_WAIT, locked_s=0 causes, at the next edge:
  - rst_out all 1, ce_out all 0, all_ready 0;
  - FSM to S_WAIT; stable and gap counters cleared;
  - lock_lost_cnt+1, saturating at 255.
- Lock loss while already in S_WAIT does not increment lock_lost_cnt.
- A glitch of locked_s low during S_STABLE restarts the debounce from 0.
- rst_out bits only ever fall in index order; they never rise individually. All bits rise together on reset or lock loss.
- Clock enable, channel k:
  - A DIV_W-bit counter cnt_k is held at 0 and ce_out[k]=0 while rst_out[k]=1.
  - Once released, cnt_k increments each cycle.
  - When cnt_k >= div_k: ce_out[k]=1 for that cycle and cnt_k returns to 0 at the next edge.
  - Result: one pulse every div_k+1 cycles. div_k=0 gives ce_out[k] constantly 1.
  - The first pulse is registered div_k+1 edges after rst_out[k] falls.
  - divs is sampled every cycle. If div_k is lowered below the current cnt_k, a pulse occurs immediately (the >= compare) and the counter wraps to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (NUM_CH=3, LOCK_STABLE=8, GAP=4, DIV_W=8):
1. Reset asserted 3 cycles with pll_locked=1 -> rst_out=3'b111, ce_out=0, all_ready=0, lock_lost_cnt=0 throughout.
2. pll_locked rises at edge E0 and stays high -> rst_out[0] falls at E0+10, rst_out[1] at E0+14, rst_out[2] and all_ready at E0+18.
3. pll_locked low for 1 cycle 5 cycles into debounce -> debounce restarts; rst_out[0] falls 10 edges after pll_locked is next sampled high; lock_lost_cnt increments once.
4. divs={8'd0,8'd2,8'd3}, all channels released -> ce_out[0] pulses every 4 cycles, ce_out[1] every 3 cycles, ce_out[2] constantly 1; first pulse of ce_out[0] is 4 edges after rst_out[0] falls.
5. In S_RUN, drop pll_locked -> 3 edges later rst_out=3'b111, ce_out=0, all_ready=0, lock_lost_cnt=1. Repeat 300 lock losses -> lock_lost_cnt holds 255.
6. Assert reset midway through the release sequence (rst_out=3'b110) -> next edge all outputs at reset values. After reset drops with pll_locked held high, the full sequence reruns with identical timing.
